// File: rtl/sha3_absorb_scheduler.sv
// -----------------------------------------------------------------------------
// sha3_absorb_scheduler
// Collects 64-bit message lanes from a valid/ready stream into one SHA3-256
// rate block (17 lanes), applies SHA-3 padding (0x06 ... 0x80) and holds the
// finished block until the round-constant counter signals FIRST_ROUND, so the
// Keccak-f core absorbs it in step with its free-running 24-round schedule.
//
// Ports:
//   CLK            clock, rising edge
//   RST_N          synchronous active-low reset
//   IN_LANE        message lane, byte k = bits [8k+7:8k]
//   IN_VALID       IN_LANE valid
//   IN_LAST        final lane of the message (qualifies IN_BYTES)
//   IN_BYTES       valid bytes in the final lane, 0..8 (larger values = 8)
//   IN_READY       lane accepted this cycle when IN_VALID is high
//   FIRST_ROUND    one-cycle pulse every 24 cycles from the round counter
//   BLOCK          assembled rate block, lane i = bits [64i+63:64i]
//   BLOCK_PENDING  BLOCK complete and waiting to be absorbed
//   ABSORB         core XORs BLOCK into its state this cycle
//   ABSORB_LAST    ABSORB of the final block of a message
// -----------------------------------------------------------------------------
module sha3_absorb_scheduler #(
   parameter int RATE_LANES = 17,
   parameter int LANE_W     = 64
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic [LANE_W-1:0]            IN_LANE,
   input  logic                         IN_VALID,
   input  logic                         IN_LAST,
   input  logic [3:0]                   IN_BYTES,
   output logic                         IN_READY,
   input  logic                         FIRST_ROUND,
   output logic [RATE_LANES*LANE_W-1:0] BLOCK,
   output logic                         BLOCK_PENDING,
   output logic                         ABSORB,
   output logic                         ABSORB_LAST
);

   localparam int                IDX_W    = $clog2(RATE_LANES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(RATE_LANES - 1);

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_PEND  = 2'd1,
      ST_EXTRA = 2'd2
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [IDX_W-1:0]  idx_r, idx_nxt_s;
   logic [LANE_W-1:0] lane_r     [RATE_LANES];
   logic [LANE_W-1:0] lane_nxt_s [RATE_LANES];
   logic              last_r, last_nxt_s;
   logic              ovf_r, ovf_nxt_s;
   logic              accept_s;
   logic [3:0]        pad_bytes_s;
   logic [LANE_W-1:0] tail_lane_s;

   assign IN_READY      = (state_r == ST_FILL);
   assign accept_s      = IN_VALID & IN_READY;
   assign BLOCK_PENDING = (state_r == ST_PEND);
   assign ABSORB        = BLOCK_PENDING & FIRST_ROUND;
   assign ABSORB_LAST   = ABSORB & last_r;

   genvar gi;
   generate
      for (gi = 0; gi < RATE_LANES; gi++) begin : g_block
         assign BLOCK[gi*LANE_W +: LANE_W] = lane_r[gi];
      end
   endgenerate

   // Clamp the final-lane byte count to one full lane.
   always_comb begin
      if (IN_BYTES > 4'd8) begin
         pad_bytes_s = 4'd8;
      end else begin
         pad_bytes_s = IN_BYTES;
      end
   end

   // Final lane: keep the valid bytes, put 0x06 right after them, zero the rest.
   always_comb begin
      tail_lane_s = '0;
      for (int k = 0; k < 8; k++) begin
         if (4'(k) < pad_bytes_s) begin
            tail_lane_s[8*k +: 8] = IN_LANE[8*k +: 8];
         end else if (4'(k) == pad_bytes_s) begin
            tail_lane_s[8*k +: 8] = 8'h06;
         end else begin
            tail_lane_s[8*k +: 8] = 8'h00;
         end
      end
   end

   // Next-state, lane-index, flag and block-contents logic.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      last_nxt_s  = last_r;
      ovf_nxt_s   = ovf_r;
      for (int i = 0; i < RATE_LANES; i++) begin
         lane_nxt_s[i] = lane_r[i];
      end

      case (state_r)
         ST_FILL: begin
            if (accept_s && IN_LAST) begin
               idx_nxt_s   = '0;
               state_nxt_s = ST_PEND;
               if ((pad_bytes_s == 4'd8) && (idx_r == LAST_IDX)) begin
                  // Block filled exactly: all padding moves to an extra block.
                  lane_nxt_s[idx_r] = IN_LANE;
                  last_nxt_s        = 1'b0;
                  ovf_nxt_s         = 1'b1;
               end else begin
                  lane_nxt_s[idx_r] = tail_lane_s;
                  if (pad_bytes_s == 4'd8) begin
                     lane_nxt_s[idx_r + 1'b1] = {{(LANE_W-8){1'b0}}, 8'h06};
                  end else begin
                     lane_nxt_s[idx_r] = tail_lane_s;
                  end
                  // OR so a coincident 0x06 in the top byte becomes 0x86.
                  lane_nxt_s[RATE_LANES-1][LANE_W-1 -: 8] =
                     lane_nxt_s[RATE_LANES-1][LANE_W-1 -: 8] | 8'h80;
                  last_nxt_s = 1'b1;
                  ovf_nxt_s  = 1'b0;
               end
            end else if (accept_s) begin
               lane_nxt_s[idx_r] = IN_LANE;
               if (idx_r == LAST_IDX) begin
                  idx_nxt_s   = '0;
                  state_nxt_s = ST_PEND;
                  last_nxt_s  = 1'b0;
               end else begin
                  idx_nxt_s = idx_r + 1'b1;
               end
            end else begin
               state_nxt_s = ST_FILL;
            end
         end

         ST_PEND: begin
            if (FIRST_ROUND) begin
               // Absorb edge: the core has taken BLOCK, start from a clean block.
               for (int i = 0; i < RATE_LANES; i++) begin
                  lane_nxt_s[i] = '0;
               end
               idx_nxt_s  = '0;
               last_nxt_s = 1'b0;
               if (ovf_r) begin
                  state_nxt_s = ST_EXTRA;
                  ovf_nxt_s   = 1'b0;
               end else begin
                  state_nxt_s = ST_FILL;
               end
            end else begin
               state_nxt_s = ST_PEND;
            end
         end

         ST_EXTRA: begin
            // Padding-only block; the block was cleared on the absorb edge.
            lane_nxt_s[0]            = {{(LANE_W-8){1'b0}}, 8'h06};
            lane_nxt_s[RATE_LANES-1] = {8'h80, {(LANE_W-8){1'b0}}};
            last_nxt_s               = 1'b1;
            state_nxt_s              = ST_PEND;
         end

         default: begin
            state_nxt_s = ST_FILL;
            idx_nxt_s   = '0;
            last_nxt_s  = 1'b0;
            ovf_nxt_s   = 1'b0;
         end
      endcase
   end

   // State, index, flags and block registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_r <= ST_FILL;
         idx_r   <= '0;
         last_r  <= 1'b0;
         ovf_r   <= 1'b0;
         for (int i = 0; i < RATE_LANES; i++) begin
            lane_r[i] <= '0;
         end
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
         last_r  <= last_nxt_s;
         ovf_r   <= ovf_nxt_s;
         for (int i = 0; i < RATE_LANES; i++) begin
            lane_r[i] <= lane_nxt_s[i];
         end
      end
   end

endmodule
